// File: rtl/dnn2ami_wr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dnn2ami_wr_sequencer
// Purpose  : Splits one macro write request into single-beat AMI writes,
//            pulling beat data from NUM_PU output buffers in round-robin order.
// Revision : 1.0 - initial release
// ============================================================================
module dnn2ami_wr_sequencer #(
    parameter int NUM_PU     = 2,
    parameter int ADDR_W     = 64,
    parameter int SIZE_W     = 10,
    parameter int DATA_W     = 512,
    parameter int BEAT_BYTES = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     macro_valid,
    output logic                     macro_ready,
    input  logic [ADDR_W-1:0]        macro_addr,
    input  logic [SIZE_W-1:0]        macro_size,
    input  logic [NUM_PU-1:0]        outbuf_empty,
    input  logic [NUM_PU*DATA_W-1:0] outbuf_data,
    output logic [NUM_PU-1:0]        outbuf_pop,
    output logic                     ami_wr_valid,
    input  logic                     ami_wr_ready,
    output logic [ADDR_W-1:0]        ami_wr_addr,
    output logic [DATA_W-1:0]        ami_wr_data,
    output logic                     macro_done,
    output logic                     busy
);

    localparam int                PU_W     = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
    localparam logic [PU_W-1:0]   LAST_PU  = PU_W'(NUM_PU - 1);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BEAT_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [SIZE_W-1:0]   left_q, left_d;
    logic [PU_W-1:0]     pu_sel_q, pu_sel_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    logic                slot_free;
    logic                load;
    logic                sel_empty;
    logic [DATA_W-1:0]   sel_data;

    // Head word and empty flag of the currently selected PU
    always_comb begin
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int p = 0; p < NUM_PU; p++) begin
            if (PU_W'(p) == pu_sel_q) begin
                sel_empty = outbuf_empty[p];
                sel_data  = outbuf_data[p*DATA_W +: DATA_W];
            end
        end
    end

    assign slot_free = !valid_q || ami_wr_ready;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        left_d     = left_q;
        pu_sel_d   = pu_sel_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        load       = 1'b0;

        if (valid_q && ami_wr_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (macro_valid) begin
                    cur_addr_d = macro_addr;
                    left_d     = macro_size;
                    pu_sel_d   = '0;
                    if (macro_size == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A stalled PU blocks the sequence; round-robin order is strict
                if (slot_free && !sel_empty) begin
                    load       = 1'b1;
                    valid_d    = 1'b1;
                    addr_d     = cur_addr_q;
                    data_d     = sel_data;
                    cur_addr_d = cur_addr_q + ADDR_INC;
                    left_d     = left_q - SIZE_W'(1);
                    pu_sel_d   = (pu_sel_q == LAST_PU) ? '0 : pu_sel_q + PU_W'(1);
                    if (left_q == SIZE_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && ami_wr_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        outbuf_pop = '0;
        for (int p = 0; p < NUM_PU; p++) begin
            outbuf_pop[p] = load && (PU_W'(p) == pu_sel_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            left_q     <= '0;
            pu_sel_q   <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            left_q     <= left_d;
            pu_sel_q   <= pu_sel_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    assign macro_ready  = (state_q == IDLE);
    assign ami_wr_valid = valid_q;
    assign ami_wr_addr  = addr_q;
    assign ami_wr_data  = data_q;
    assign macro_done   = done_q;
    assign busy         = (state_q != IDLE) || valid_q;

endmodule
`default_nettype wire

// File: doc/dnn2ami_wr_sequencer.md
# dnn2ami_wr_sequencer

Sequencer for the DNN2AMI write path. It takes one macro write request at a time from the macro write queue (base address, length in beats) and fractures it into single-beat AMI write requests. Beat data is gathered from NUM_PU per-PU output buffers in round-robin order. It drives the buffers' pop strobes and pulses a completion flag when the last beat of a macro request has been accepted by AMI.

## Interface
Parameters:
- NUM_PU, 2, number of PU output buffers (≥1)
- ADDR_W, 64, byte-address width
- SIZE_W, 10, macro length field width (beats)
- DATA_W, 512, beat width
- BEAT_BYTES, 64, address increment per beat

Ports:
- clock  in  1  sole clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- macro_valid  in  1  macro request present (macro write queue not empty)
- macro_ready  out  1  sequencer accepts a macro request (queue deq)
- macro_addr  in  ADDR_W  macro base byte address
- macro_size  in  SIZE_W  macro length in beats
- outbuf_empty  in  NUM_PU  per-PU output buffer empty
- outbuf_data  in  NUM_PU*DATA_W  per-PU head word; PU p at bits [p*DATA_W +: DATA_W]
- outbuf_pop  out  NUM_PU  one-hot pop strobe
- ami_wr_valid  out  1  AMI write beat valid
- ami_wr_ready  in  1  AMI accepts beat
- ami_wr_addr  out  ADDR_W  beat byte address
- ami_wr_data  out  DATA_W  beat data
- macro_done  out  1  one-cycle pulse: macro request fully issued
- busy  out  1  state != IDLE or output slot occupied

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - macro_ready=1.
  - On macro_valid: latch cur_addr=macro_addr and left=macro_size, and set pu_sel=0.
  - If macro_size==0: stay IDLE and pulse macro_done next cycle.
  - Otherwise go to ISSUE.
- ISSUE:
  - macro_ready=0.
  - A beat is loaded when slot_free && !outbuf_empty[pu_sel], where slot_free = !ami_wr_valid || ami_wr_ready.
  - On load:
    - outbuf_pop[pu_sel]=1, combinational, same cycle.
    - Output register takes addr=cur_addr and data=outbuf_data[pu_sel].
    - cur_addr += BEAT_BYTES, wrapping modulo 2^ADDR_W.
    - left -= 1.
    - pu_sel = (pu_sel+1) mod NUM_PU.
  - If left==1 on load, go to DRAIN.
  - If the selected PU is empty, stall. Never skip to another PU.
- DRAIN: no loads. When ami_wr_valid && ami_wr_ready, clear valid, pulse macro_done, go to IDLE.
- Output register holds addr and data stable while ami_wr_valid && !ami_wr_ready.
- outbuf_pop is never asserted outside ISSUE or when the selected buffer is empty.
- At most one bit of outbuf_pop is set in any cycle.

## Timing
- Reset (reset_n=0, async):
  - State=IDLE.
  - ami_wr_valid=0, ami_wr_addr=0, ami_wr_data=0, macro_done=0, busy=0, outbuf_pop=0.
  - macro_ready=1, because it is decoded from IDLE.
  - cur_addr, left and pu_sel are cleared.
- Reset mid-operation discards all in-flight beats and pending count. No macro_done is issued.
- Accept at edge E0. In cycle E0→E1 the state is ISSUE and the first pop may occur. ami_wr_valid is high from edge E1 at the earliest.
- Throughput: 1 beat/cycle with ami_wr_ready=1 and no buffer empty.
- N-beat macro with no stalls: the last beat is accepted at edge E0+N+1. macro_done is high for cycle E0+N+1→E0+N+2.
- macro_ready is high in that same cycle. The next macro is accepted at that edge, which gives a one-cycle bubble between macros.
- macro_size==0: accepted at E0, macro_done high during E0→E1. ami_wr_valid stays 0.
- Pop and AMI accept in the same cycle (slot_free via ready) are legal; the register is reloaded at that edge.

## Test plan
- NUM_PU=2, base 0x1000, size 4, both buffers non-empty, ready=1:
  - AMI addrs 0x1000, 0x1040, 0x1080, 0x10C0.
  - Pops PU0, PU1, PU0, PU1.
  - Data matches heads in order.
  - Single macro_done one cycle after the 4th accept.
- Same request with ami_wr_ready held low 3 cycles on beat 2:
  - addr 0x1040 and data held stable.
  - No pop while the slot is full.
  - 4 beats total, one macro_done.
- PU1 empty for 5 cycles after beat 1:
  - Sequencer stalls (valid low after beat 1 accepted).
  - No PU0 pop.
  - Resumes with PU1 data for beat 2.
- macro_size=0 then size 1 back-to-back:
  - First: macro_done pulse, no AMI beat.
  - Second: one beat at its base, one pop PU0, one macro_done.
- Base 0xFFFF_FFFF_FFFF_FFC0, size 2: beat 2 addr wraps to 0x0.
- reset_n low during ISSUE of an 8-beat macro after 3 beats:
  - Outputs reach reset values immediately.
  - No macro_done.
  - macro_ready=1.
  - The next macro starts at PU0.
